boot_loader: RTL and testbench
==============================

# boot_loader

Hardware program loader for the Ember core. It accepts instruction words from a host stream and writes them little-endian, byte by byte, into the byte-wide L3 memory write port. It holds the core in reset during the load, then releases the reset and enables a selectable set of hardware threads. It is a parametrised successor to bench-side preload and enable sequencing, and sits between the host/debug port, L3, and the core's reset and enable inputs.

## Interface
Parameters:
- ADDR_W, 16, L3 byte-address width.
- WORD_BYTES, 4, bytes per instruction word; must be at least 1.
- THREADS, 2, hardware thread count.
- BASE_ADDR, 0, first L3 byte address written.
- RELEASE_DELAY, 2, cycles between core reset deassertion and enable assertion; must be at least 1.

Ports:
- clk  in  1  single clock. Everything is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle load request.
- thread_mask  in  THREADS  threads to enable; latched on an accepted start.
- in_valid  in  1  host word valid.
- in_ready  out  1  loader can accept a word.
- in_data  in  8*WORD_BYTES  instruction word. Byte 0 is in_data[7:0].
- in_last  in  1  marks the final word of the program.
- mem_we  out  1  L3 byte write strobe.
- mem_addr  out  ADDR_W  L3 byte address.
- mem_wdata  out  8  L3 write byte.
- core_rst  out  1  core reset, active-high.
- core_enable  out  1  core enable.
- t_enable  out  THREADS  per-thread enable.
- busy  out  1  load in progress.
- done  out  1  program running.
- err  out  1  address overflow.

## Operation
States are IDLE, LOAD, UNPACK, RELEASE, RUN and ERROR.

- **Reset values:** state IDLE, core_rst=1, core_enable=0, t_enable=0, mem_we=0, mem_addr=0, mem_wdata=0, in_ready=0, busy=0, done=0, err=0.
- **IDLE:**
  - On start: latch thread_mask, set addr=BASE_ADDR, go to LOAD.
  - core_rst stays 1.
- **LOAD:**
  - in_ready=1.
  - A word is accepted when in_valid and in_ready are both high. On acceptance, latch the word and in_last.
  - If addr + WORD_BYTES > 2^ADDR_W, go to ERROR without writing any byte. Otherwise go to UNPACK with byte index k=0.
- **UNPACK:**
  - in_ready=0.
  - Each cycle: mem_we=1, mem_addr=addr, mem_wdata=word byte k. Then addr and k increment.
  - After byte WORD_BYTES-1: go to RELEASE if the latched in_last is set, otherwise go back to LOAD.
  - A word ending exactly at address 2^ADDR_W-1 is legal.
- **RELEASE:**
  - core_rst=0.
  - Count RELEASE_DELAY cycles, then go to RUN.
- **RUN:**
  - core_enable=1, t_enable=latched mask, done=1.
  - A mask of all zeros is legal: core_enable=1 and t_enable=0.
  - start in RUN restarts the load: core_rst=1, core_enable=0, t_enable=0, done=0, latch the new mask, addr=BASE_ADDR, go to LOAD.
- **ERROR:**
  - err=1, core_rst=1, enables 0.
  - start clears err and begins a new load, as from IDLE.
- **busy:** 1 in LOAD, UNPACK and RELEASE.
- **start ignored:** start has no effect in LOAD, UNPACK and RELEASE.
- **Outputs:** all outputs are registered.
- **rst at any point** (including mid-UNPACK): at the next edge all outputs return to their reset values. L3 contents already written are left unchanged.

## Timing
- **start to in_ready:** start sampled at edge E gives in_ready=1 in cycle E+1.
- **Byte writes:** for a word accepted at edge A, byte k is presented in cycle A+1+k and written at edge A+2+k.
- **Next word:** in_ready is 0 for WORD_BYTES cycles and returns to 1 in cycle A+1+WORD_BYTES. Throughput is one word per WORD_BYTES+1 cycles.
- **Last word:** when the final byte of the in_last word is written at edge W, core_rst falls in cycle W.
- **Enable:** core_enable, t_enable and done rise RELEASE_DELAY cycles after core_rst falls.
- **Overflow:** err rises in the cycle after the offending word's acceptance edge.

## Test plan
- **Two-word load:** defaults, mask=2'b01, stream 32'h11522011 then 32'h00110421 (in_last) → L3[0..7] = 11,20,52,11,21,04,11,00. core_rst falls after the 8th write. core_enable=1 and t_enable=01 appear 2 cycles later, done=1.
- **Backpressure:** in_valid held high continuously → in_ready pattern is 1,0,0,0,0,1. Exactly 4 mem_we pulses per word, with no dropped or duplicated bytes.
- **Overflow:** ADDR_W=4, BASE_ADDR=12, stream 2 words → first word written to L3[12..15]. Second word gives err=1 with no write, core_rst stays 1. A following start clears err.
- **Reset mid-UNPACK:** assert rst during byte 2 of a word → next cycle all outputs are at reset values and no further mem_we pulses occur.
- **Restart from RUN:** after a completed load, issue start with mask=2'b10 → core_rst=1 and enables drop the next cycle. After the reload, t_enable=10.
- **Ignored start and empty mask:** start during UNPACK has no effect. A load with mask=0 → core_enable=1, t_enable=0, done=1.

Source files
------------

// File: rtl/boot_loader.sv
// boot_loader: loads a program from a host word stream into the byte-wide L3 write port.
// Each word is written little-endian, one byte per cycle. The core is held in reset while the
// program loads. After the word flagged in_last is written, the core reset is released and,
// RELEASE_DELAY cycles later, the core and the selected hardware threads are enabled.
//
// Ports:
//   clk, rst           single rising-edge clock, synchronous active-high reset
//   start, thread_mask load request (single cycle) and thread set latched with it
//   in_valid/in_ready  host word handshake; in_data byte 0 is in_data[7:0], in_last ends program
//   mem_we/addr/wdata  L3 byte write port
//   core_rst           core reset (active-high); core_enable, t_enable: core/thread enables
//   busy, done, err    load in progress, program running, address overflow
// All outputs are registered.
module boot_loader #(
    parameter int unsigned ADDR_W        = 16,
    parameter int unsigned WORD_BYTES    = 4,
    parameter int unsigned THREADS       = 2,
    parameter int unsigned BASE_ADDR     = 0,
    parameter int unsigned RELEASE_DELAY = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [THREADS-1:0]      thread_mask,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [8*WORD_BYTES-1:0] in_data,
    input  logic                    in_last,
    output logic                    mem_we,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [7:0]              mem_wdata,
    output logic                    core_rst,
    output logic                    core_enable,
    output logic [THREADS-1:0]      t_enable,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StUnpack,
        StRelease,
        StRun,
        StError
    } state_e;

    localparam int unsigned KW = $clog2(WORD_BYTES + 1);
    localparam int unsigned CW = (RELEASE_DELAY > 1) ? $clog2(RELEASE_DELAY) : 1;

    state_e                  state_q;
    // One extra bit so the address just past the top of L3 is representable.
    logic [ADDR_W:0]         addr_q;
    logic [KW-1:0]           k_q;
    logic [CW-1:0]           cnt_q;
    logic [8*WORD_BYTES-1:0] word_q;
    logic                    last_q;
    logic [THREADS-1:0]      mask_q;

    logic [ADDR_W+1:0]       end_addr;
    logic                    overflow;

    // A word fits if its last byte lands at or below 2^ADDR_W - 1.
    always_comb begin
        end_addr = {1'b0, addr_q} + (ADDR_W + 2)'(WORD_BYTES);
        overflow = end_addr > ((ADDR_W + 2)'(1) << ADDR_W);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            k_q         <= '0;
            cnt_q       <= '0;
            word_q      <= '0;
            last_q      <= 1'b0;
            mask_q      <= '0;
            in_ready    <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            core_rst    <= 1'b1;
            core_enable <= 1'b0;
            t_enable    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            unique case (state_q)
                // A new load may begin from rest, from a running program or after an error.
                StIdle, StRun, StError: begin
                    if (start) begin
                        state_q     <= StLoad;
                        mask_q      <= thread_mask;
                        addr_q      <= (ADDR_W + 1)'(BASE_ADDR);
                        in_ready    <= 1'b1;
                        busy        <= 1'b1;
                        err         <= 1'b0;
                        done        <= 1'b0;
                        core_rst    <= 1'b1;
                        core_enable <= 1'b0;
                        t_enable    <= '0;
                    end
                end

                StLoad: begin
                    if (in_valid && in_ready) begin
                        in_ready <= 1'b0;
                        if (overflow) begin
                            state_q <= StError;
                            err     <= 1'b1;
                            busy    <= 1'b0;
                        end else begin
                            // Byte 0 goes out straight away; the rest are shifted down.
                            state_q   <= StUnpack;
                            word_q    <= in_data >> 8;
                            last_q    <= in_last;
                            mem_we    <= 1'b1;
                            mem_addr  <= addr_q[ADDR_W-1:0];
                            mem_wdata <= in_data[7:0];
                            addr_q    <= addr_q + (ADDR_W + 1)'(1);
                            k_q       <= KW'(1);
                        end
                    end
                end

                StUnpack: begin
                    if (k_q == KW'(WORD_BYTES)) begin
                        mem_we <= 1'b0;
                        if (last_q) begin
                            state_q  <= StRelease;
                            core_rst <= 1'b0;
                            cnt_q    <= '0;
                        end else begin
                            state_q  <= StLoad;
                            in_ready <= 1'b1;
                        end
                    end else begin
                        mem_we    <= 1'b1;
                        mem_addr  <= addr_q[ADDR_W-1:0];
                        mem_wdata <= word_q[7:0];
                        word_q    <= word_q >> 8;
                        addr_q    <= addr_q + (ADDR_W + 1)'(1);
                        k_q       <= k_q + KW'(1);
                    end
                end

                StRelease: begin
                    if (cnt_q == CW'(RELEASE_DELAY - 1)) begin
                        state_q     <= StRun;
                        core_enable <= 1'b1;
                        t_enable    <= mask_q;
                        done        <= 1'b1;
                        busy        <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end

                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_boot_loader.sv
// Self-checking bench for boot_loader: a default-parameter instance for loading, handshake,
// release timing, restart, ignored start, empty mask and reset, plus a small-address instance
// (ADDR_W=4, BASE_ADDR=12) for the overflow path. Written bytes are checked against a
// scoreboard of expected {address, byte} pairs pushed when each word is driven.
module tb_boot_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, in_valid, in_ready, in_last;
    logic [1:0]  thread_mask, t_enable;
    logic [31:0] in_data;
    logic        mem_we, core_rst, core_enable, busy, done, err;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;

    logic        ov_start, ov_in_valid, ov_in_ready, ov_in_last;
    logic [1:0]  ov_thread_mask, ov_t_enable;
    logic [31:0] ov_in_data;
    logic        ov_mem_we, ov_core_rst, ov_core_enable, ov_busy, ov_done, ov_err;
    logic [3:0]  ov_mem_addr;
    logic [7:0]  ov_mem_wdata;

    boot_loader dut (
        .clk(clk), .rst(rst), .start(start), .thread_mask(thread_mask),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .core_rst(core_rst), .core_enable(core_enable), .t_enable(t_enable),
        .busy(busy), .done(done), .err(err)
    );

    boot_loader #(.ADDR_W(4), .BASE_ADDR(12)) dut_ov (
        .clk(clk), .rst(rst), .start(ov_start), .thread_mask(ov_thread_mask),
        .in_valid(ov_in_valid), .in_ready(ov_in_ready), .in_data(ov_in_data),
        .in_last(ov_in_last), .mem_we(ov_mem_we), .mem_addr(ov_mem_addr),
        .mem_wdata(ov_mem_wdata), .core_rst(ov_core_rst), .core_enable(ov_core_enable),
        .t_enable(ov_t_enable), .busy(ov_busy), .done(ov_done), .err(ov_err)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    int          n_writes = 0;
    int          ov_writes = 0;
    logic [23:0] exp_q[$];
    logic [11:0] ov_exp_q[$];
    logic [15:0] exp_addr;
    logic [7:0]  l3 [0:255];
    logic [7:0]  exp_l3 [8];

    localparam logic [63:0] RstOuts =
        64'({1'b0, 1'b0, 16'h0, 8'h0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0});

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return 64'({in_ready, mem_we, mem_addr, mem_wdata, core_rst, core_enable, t_enable,
                    busy, done, err});
    endfunction

    task automatic push_word(input logic [31:0] d);
        for (int b = 0; b < 4; b++) begin
            exp_q.push_back({exp_addr, d[8*b +: 8]});
            exp_addr = exp_addr + 16'd1;
        end
    endtask

    // Drives one word from a negedge and returns at the negedge after its acceptance edge.
    task automatic send_word(input logic [31:0] d, input logic last);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (in_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("send_ready_timeout", 64'(in_ready), 64'd1);
        push_word(d);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (done !== 1'b1 && t < 60) begin
            @(negedge clk);
            t++;
        end
        check("done_timeout", 64'(done), 64'd1);
    endtask

    task automatic start_load(input logic [1:0] mask);
        start       = 1'b1;
        thread_mask = mask;
        @(negedge clk);
        start       = 1'b0;
        exp_addr    = 16'd0;
    endtask

    // Scoreboard monitors, sampling on the falling edge.
    initial begin
        logic [23:0] e;
        forever begin
            @(negedge clk);
            if (mem_we === 1'b1) begin
                n_writes++;
                l3[mem_addr[7:0]] = mem_wdata;
                if (exp_q.size() == 0) begin
                    check("spurious_write", 64'(exp_q.size()), 64'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", 64'(mem_addr), 64'(e[23:8]));
                    check("wr_data", 64'(mem_wdata), 64'(e[7:0]));
                end
            end
        end
    end

    initial begin
        logic [11:0] e;
        forever begin
            @(negedge clk);
            if (ov_mem_we === 1'b1) begin
                ov_writes++;
                if (ov_exp_q.size() == 0) begin
                    check("ov_spurious_write", 64'(ov_exp_q.size()), 64'd1);
                end else begin
                    e = ov_exp_q.pop_front();
                    check("ov_wr_addr", 64'(ov_mem_addr), 64'(e[11:8]));
                    check("ov_wr_data", 64'(ov_mem_wdata), 64'(e[7:0]));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   t, snap;
        logic prev_we;
        exp_l3 = '{8'h11, 8'h20, 8'h52, 8'h11, 8'h21, 8'h04, 8'h11, 8'h00};
        rst = 1'b1; start = 1'b0; thread_mask = '0; in_valid = 1'b0; in_data = '0;
        in_last = 1'b0; exp_addr = '0;
        ov_start = 1'b0; ov_thread_mask = '0; ov_in_valid = 1'b0; ov_in_data = '0;
        ov_in_last = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outs", outs(), RstOuts);
        check("ov_reset_core_rst", 64'(ov_core_rst), 64'd1);
        rst = 1'b0;
        @(negedge clk);
        check("idle_outs", outs(), RstOuts);

        // Two-word load with continuous in_valid.
        start_load(2'b01);
        check("start_in_ready", 64'(in_ready), 64'd1);
        check("start_busy", 64'(busy), 64'd1);
        in_valid = 1'b1; in_data = 32'h11522011; in_last = 1'b0;
        push_word(32'h11522011);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bp_ready_low", 64'(in_ready), 64'd0);
        end
        @(negedge clk);
        check("bp_ready_high", 64'(in_ready), 64'd1);
        check("bp_writes_word1", 64'(n_writes), 64'd4);
        in_data = 32'h00110421; in_last = 1'b1;
        push_word(32'h00110421);
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        t = 0; prev_we = 1'b0;
        while (core_rst !== 1'b0 && t < 50) begin
            prev_we = mem_we;
            @(negedge clk);
            t++;
        end
        check("core_rst_fall", 64'(core_rst), 64'd0);
        check("core_rst_fall_at_last_write", 64'(prev_we), 64'd1);
        check("writes_total", 64'(n_writes), 64'd8);
        check("enable_delay0", 64'(core_enable), 64'd0);
        @(negedge clk);
        check("enable_delay1", 64'(core_enable), 64'd0);
        @(negedge clk);
        check("run_core_enable", 64'(core_enable), 64'd1);
        check("run_t_enable", 64'(t_enable), 64'd1);
        check("run_done", 64'(done), 64'd1);
        check("run_busy", 64'(busy), 64'd0);
        for (int i = 0; i < 8; i++) check("l3_byte", 64'(l3[i]), 64'(exp_l3[i]));

        // Restart from RUN, with a start during UNPACK that must be ignored.
        start_load(2'b10);
        check("restart_core_rst", 64'(core_rst), 64'd1);
        check("restart_enables", 64'({core_enable, t_enable, done}), 64'd0);
        check("restart_in_ready", 64'(in_ready), 64'd1);
        in_valid = 1'b1; in_data = 32'hA5B6C7D8; in_last = 1'b1;
        push_word(32'hA5B6C7D8);
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        @(negedge clk);
        start = 1'b1; thread_mask = 2'b11;
        @(negedge clk);
        start = 1'b0; thread_mask = 2'b00;
        check("ignored_start_we", 64'(mem_we), 64'd1);
        check("ignored_start_ready", 64'(in_ready), 64'd0);
        check("ignored_start_addr", 64'(mem_addr), 64'd2);
        wait_done();
        check("restart_t_enable", 64'(t_enable), 64'd2);
        check("restart_core_enable", 64'(core_enable), 64'd1);

        // Empty thread mask.
        start_load(2'b00);
        send_word(32'h0BADF00D, 1'b1);
        wait_done();
        check("empty_mask_core_enable", 64'(core_enable), 64'd1);
        check("empty_mask_t_enable", 64'(t_enable), 64'd0);

        // Reset while byte 2 of a word is on the port.
        start_load(2'b01);
        send_word(32'hCAFEBABE, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("pre_reset_byte2", 64'(mem_wdata), 64'hFE);
        rst = 1'b1;
        @(negedge clk);
        check("mid_unpack_reset_outs", outs(), RstOuts);
        exp_q.delete();
        snap = n_writes;
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("no_writes_after_reset", 64'(n_writes), 64'(snap));
        check("idle_after_reset", outs(), RstOuts);

        // Overflow on the 16-byte instance starting at address 12.
        ov_start = 1'b1; ov_thread_mask = 2'b01;
        @(negedge clk);
        ov_start = 1'b0;
        check("ov_start_ready", 64'(ov_in_ready), 64'd1);
        ov_in_valid = 1'b1; ov_in_data = 32'h44332211;
        for (int b = 0; b < 4; b++) ov_exp_q.push_back({4'(12 + b), ov_in_data[8*b +: 8]});
        @(negedge clk);
        ov_in_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("ov_ready_after_word1", 64'(ov_in_ready), 64'd1);
        check("ov_writes_word1", 64'(ov_writes), 64'd4);
        ov_in_valid = 1'b1; ov_in_data = 32'h88776655;
        @(negedge clk);
        ov_in_valid = 1'b0;
        check("ov_err", 64'(ov_err), 64'd1);
        check("ov_core_rst", 64'(ov_core_rst), 64'd1);
        check("ov_no_we", 64'(ov_mem_we), 64'd0);
        check("ov_busy", 64'(ov_busy), 64'd0);
        check("ov_in_ready", 64'(ov_in_ready), 64'd0);
        repeat (4) @(negedge clk);
        check("ov_no_extra_writes", 64'(ov_writes), 64'd4);
        check("ov_err_held", 64'({ov_err, ov_core_enable, ov_t_enable}), 64'h8);
        ov_start = 1'b1;
        @(negedge clk);
        ov_start = 1'b0;
        check("ov_err_cleared", 64'(ov_err), 64'd0);
        check("ov_reload_ready", 64'(ov_in_ready), 64'd1);

        check("sb_empty", 64'(exp_q.size()), 64'd0);
        check("ov_sb_empty", 64'(ov_exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
